// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared BCD constants and range helper for the date/time field counters
package contador_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/bin2bcd_2dig.sv
// rtl/bin2bcd_2dig.sv - combinational binary (0..99) to two BCD digits
module bin2bcd_2dig
  import contador_pkg::*;
#(
  parameter int W = 7
) (
  input  logic [W-1:0]     i_bin,
  output logic [BCD_W-1:0] o_tens,
  output logic [BCD_W-1:0] o_units
);

  // Input is bounded to 0..99 by the counter, so the quotient always fits one digit.
  assign o_tens  = BCD_W'(i_bin / W'(10));
  assign o_units = BCD_W'(i_bin % W'(10));

endmodule

// File: rtl/contador_ad_mod_bcd.sv
// rtl/contador_ad_mod_bcd.sv - up/down modulo counter with BCD output, runtime limit, load and wrap ticks
module contador_ad_mod_bcd
  import contador_pkg::*;
#(
  parameter int W       = 7,
  parameter int MIN_VAL = 1,
  parameter int MAX_VAL = 12,
  parameter int RST_VAL = 1,
  parameter int USE_LIM = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enUP,
  input  logic             enDOWN,
  input  logic [W-1:0]     max_lim,
  input  logic             load,
  input  logic [BCD_W-1:0] load_d1,
  input  logic [BCD_W-1:0] load_d0,
  output logic [BCD_W-1:0] digit1,
  output logic [BCD_W-1:0] digit0,
  output logic [W-1:0]     count,
  output logic             carry,
  output logic             borrow,
  output logic             load_err
);

  localparam logic [W-1:0] C_MIN = W'(MIN_VAL);
  localparam logic [W-1:0] C_MAX = W'(MAX_VAL);
  localparam logic [W-1:0] C_RST = W'(RST_VAL);

  logic [W-1:0] r_count;
  logic         r_up_q;
  logic         r_dn_q;
  logic         r_carry;
  logic         r_borrow;
  logic         r_load_err;

  logic [W-1:0] w_lim;
  logic         w_up_tick;
  logic         w_dn_tick;
  logic [7:0]   w_load_val;
  logic         w_load_ok;
  logic [W-1:0] w_count_nxt;
  logic         w_carry_nxt;
  logic         w_borrow_nxt;
  logic         w_load_err_nxt;

  // Runtime limit clamped into the static range so a bad max_lim can never widen it.
  always_comb begin
    w_lim = C_MAX;
    if (USE_LIM != 0) begin
      if (max_lim < C_MIN)
        w_lim = C_MIN;
      else if (max_lim > C_MAX)
        w_lim = C_MAX;
      else
        w_lim = max_lim;
    end
  end

  assign w_up_tick  = enUP & ~r_up_q;
  assign w_dn_tick  = enDOWN & ~r_dn_q;
  assign w_load_val = ({4'd0, load_d1} * 8'd10) + {4'd0, load_d0};
  assign w_load_ok  = (load_d1 <= BCD_MAX) && (load_d0 <= BCD_MAX) &&
                      in_range(int'(w_load_val), MIN_VAL, int'(w_lim));

  always_comb begin
    w_count_nxt    = r_count;
    w_carry_nxt    = 1'b0;
    w_borrow_nxt   = 1'b0;
    w_load_err_nxt = 1'b0;
    if (load) begin
      if (w_load_ok)
        w_count_nxt = W'(w_load_val);
      else
        w_load_err_nxt = 1'b1;
    end else if (w_up_tick && w_dn_tick) begin
      w_count_nxt = r_count;
    end else if (w_up_tick) begin
      if (r_count >= w_lim) begin
        w_count_nxt = C_MIN;
        w_carry_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count + W'(1);
      end
    end else if (w_dn_tick) begin
      if (r_count == C_MIN) begin
        w_count_nxt  = w_lim;
        w_borrow_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count - W'(1);
      end
    end else if (r_count > w_lim) begin
      w_count_nxt = w_lim;
    end
  end

  // Edge registers track the lines even in reset so a held button does not step on release.
  always_ff @(posedge clk) begin
    r_up_q <= enUP;
    r_dn_q <= enDOWN;
    if (reset) begin
      r_count    <= C_RST;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_carry    <= w_carry_nxt;
      r_borrow   <= w_borrow_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  bin2bcd_2dig #(
    .W (W)
  ) u_bcd (
    .i_bin   (r_count),
    .o_tens  (digit1),
    .o_units (digit0)
  );

  assign count    = r_count;
  assign carry    = r_carry;
  assign borrow   = r_borrow;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_contador_ad_mod_bcd.sv
// tb/tb_contador_ad_mod_bcd.sv - directed self-checking bench for contador_ad_mod_bcd
module tb_contador_ad_mod_bcd;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_up, a_dn, a_load;
  logic [3:0] a_d1, a_d0;
  logic [6:0] a_lim;
  logic [3:0] a_dig1, a_dig0;
  logic [6:0] a_cnt;
  logic       a_carry, a_borrow, a_err;
  logic       b_up, b_dn, b_load;
  logic [3:0] b_d1, b_d0;
  logic [6:0] b_lim;
  logic [3:0] b_dig1, b_dig0;
  logic [6:0] b_cnt;
  logic       b_carry, b_borrow, b_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  contador_ad_mod_bcd #(.W(7), .MIN_VAL(1), .MAX_VAL(12), .RST_VAL(1), .USE_LIM(0)) u_dut_a (
    .clk(clk), .reset(reset), .enUP(a_up), .enDOWN(a_dn), .max_lim(a_lim),
    .load(a_load), .load_d1(a_d1), .load_d0(a_d0), .digit1(a_dig1), .digit0(a_dig0),
    .count(a_cnt), .carry(a_carry), .borrow(a_borrow), .load_err(a_err)
  );

  contador_ad_mod_bcd #(.W(7), .MIN_VAL(1), .MAX_VAL(31), .RST_VAL(1), .USE_LIM(1)) u_dut_b (
    .clk(clk), .reset(reset), .enUP(b_up), .enDOWN(b_dn), .max_lim(b_lim),
    .load(b_load), .load_d1(b_d1), .load_d0(b_d0), .digit1(b_dig1), .digit0(b_dig0),
    .count(b_cnt), .carry(b_carry), .borrow(b_borrow), .load_err(b_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_up = 1'b1; a_dn = 1'b0; a_load = 1'b0; a_d1 = 4'd0; a_d0 = 4'd0; a_lim = 7'd0;
    b_up = 1'b0; b_dn = 1'b0; b_load = 1'b0; b_d1 = 4'd0; b_d0 = 4'd0; b_lim = 7'd31;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_count", a_cnt, 1);
    check("rst_dig1", a_dig1, 0);
    check("rst_dig0", a_dig0, 1);
    check("rst_pulses", {a_carry, a_borrow, a_err}, 0);
    tick();
    check("held_up_no_step", a_cnt, 1);
    a_up = 1'b0; tick();
    a_up = 1'b1; tick();
    check("up_after_release", a_cnt, 2);
    a_up = 1'b0; tick();

    a_load = 1'b1; a_d1 = 4'd1; a_d0 = 4'd1; tick();
    a_load = 1'b0;
    check("load_11", a_cnt, 11);
    a_up = 1'b1; tick(); a_up = 1'b0;
    check("up_to_12", a_cnt, 12);
    check("dig_12", {a_dig1, a_dig0}, 8'h12);
    check("no_carry_12", a_carry, 0);
    tick();
    a_up = 1'b1; tick(); a_up = 1'b0;
    check("wrap_up_count", a_cnt, 1);
    check("wrap_up_carry", a_carry, 1);
    tick();
    check("carry_one_cycle", a_carry, 0);

    a_dn = 1'b1; tick(); a_dn = 1'b0;
    check("wrap_dn_count", a_cnt, 12);
    check("wrap_dn_borrow", a_borrow, 1);
    tick();
    check("borrow_one_cycle", a_borrow, 0);
    a_up = 1'b1; a_dn = 1'b1; tick();
    check("both_hold", a_cnt, 12);
    check("both_no_pulse", {a_carry, a_borrow}, 0);
    a_up = 1'b0; a_dn = 1'b0; tick();
    check("idle_hold", a_cnt, 12);

    a_load = 1'b1; a_d1 = 4'd0; a_d0 = 4'd7; tick();
    check("load_7", a_cnt, 7);
    check("load_7_dig", {a_dig1, a_dig0}, 8'h07);
    check("load_7_no_err", a_err, 0);
    a_d1 = 4'd1; a_d0 = 4'd5; tick();
    check("load_15_err", a_err, 1);
    check("load_15_hold", a_cnt, 7);
    a_load = 1'b0; tick();
    check("err_one_cycle", a_err, 0);
    a_load = 1'b1; a_d1 = 4'd0; a_d0 = 4'hA; tick();
    check("load_bad_digit_err", a_err, 1);
    check("load_bad_digit_hold", a_cnt, 7);
    a_d0 = 4'd0; tick();
    check("load_0_below_min_err", a_err, 1);
    a_d0 = 4'd9; a_up = 1'b1; tick();
    check("load_beats_step", a_cnt, 9);
    check("load_beats_step_carry", a_carry, 0);
    a_load = 1'b0; a_up = 1'b0;
    a_d1 = 4'd1; a_d0 = 4'd2; a_load = 1'b1; tick();
    check("load_12_max", a_cnt, 12);
    a_load = 1'b0; tick();

    a_up = 1'b1; a_load = 1'b1; a_d0 = 4'hB; reset = 1'b1; tick();
    check("rst_mid_count", a_cnt, 1);
    check("rst_mid_pulses", {a_carry, a_borrow, a_err}, 0);
    reset = 1'b0; a_up = 1'b0; a_load = 1'b0; tick();
    check("rst_mid_after", a_cnt, 1);

    b_load = 1'b1; b_d1 = 4'd3; b_d0 = 4'd1; tick();
    b_load = 1'b0;
    check("b_load_31", b_cnt, 31);
    check("b_dig_31", {b_dig1, b_dig0}, 8'h31);
    b_lim = 7'd28; tick();
    check("b_clamp_28", b_cnt, 28);
    check("b_clamp_no_pulse", {b_carry, b_borrow}, 0);
    b_up = 1'b1; tick(); b_up = 1'b0;
    check("b_wrap_count", b_cnt, 1);
    check("b_wrap_carry", b_carry, 1);
    tick();
    b_dn = 1'b1; tick(); b_dn = 1'b0;
    check("b_borrow_to_lim", b_cnt, 28);
    check("b_borrow_pulse", b_borrow, 1);
    tick();
    b_load = 1'b1; b_d1 = 4'd2; b_d0 = 4'd9; tick();
    check("b_load_over_lim_err", b_err, 1);
    check("b_load_over_lim_hold", b_cnt, 28);
    b_load = 1'b0; b_lim = 7'd0; tick();
    check("b_lim_low_clamp", b_cnt, 1);
    b_lim = 7'd99; b_load = 1'b1; b_d1 = 4'd3; b_d0 = 4'd1; tick();
    b_load = 1'b0;
    check("b_lim_high_clamp_load", b_cnt, 31);
    b_up = 1'b1; tick(); b_up = 1'b0;
    check("b_lim_high_wrap", b_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
